servant_timer_nch: RTL and testbench

Parametrised multi-channel timer peripheral for the servant SoC, the next generation of the single-compare servant timer. One prescaled up-counter with a programmable wrap value (TOP) drives CHANNELS independent compare channels, each with a sticky pending flag and an interrupt mask. It sits on the servant_mux timer Wishbone slot, and its combined interrupt feeds the SERV core's timer interrupt input.

---
 rtl/servant_timer_nch_if.sv | 19 +
 rtl/servant_timer_nch.sv | 205 ++++++++++++++++++++
 tb/tb_servant_timer_nch.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/servant_timer_nch_if.sv
// Wishbone timer-slot bus between servant_mux (master) and servant_timer_nch (slave).
interface servant_timer_nch_if;
  logic [3:0]  i_wb_adr;
  logic [31:0] i_wb_dat;
  logic        i_wb_we;
  logic        i_wb_cyc;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack;

  modport master (
    output i_wb_adr, i_wb_dat, i_wb_we, i_wb_cyc,
    input  o_wb_rdt, o_wb_ack
  );

  modport slave (
    input  i_wb_adr, i_wb_dat, i_wb_we, i_wb_cyc,
    output o_wb_rdt, o_wb_ack
  );
endinterface

// File: rtl/servant_timer_nch.sv
// Multi-channel prescaled timer with per-channel compare, sticky pending and mask.
// Optional one-shot mode (CTRL[1]) is enabled by defining SERVANT_TIMER_NCH_ONESHOT_EN.
module servant_timer_nch #(
  parameter int WIDTH      = 32,
  parameter int CHANNELS   = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  servant_timer_nch_if.slave  wb,
  output logic                o_irq,
  output logic [CHANNELS-1:0] o_irq_vec
);

  typedef enum logic [3:0] {
    REG_CTRL    = 4'd0,
    REG_COUNT   = 4'd1,
    REG_TOP     = 4'd2,
    REG_PENDING = 4'd3,
    REG_MASK    = 4'd4
  } reg_idx_e;

  typedef logic [WIDTH-1:0] word_t;

  logic                  en_q, en_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  word_t                 count_q, count_d;
  word_t                 top_q, top_d;
  word_t                 cmp_q [CHANNELS];
  word_t                 cmp_d [CHANNELS];
  logic [CHANNELS-1:0]   pending_q, pending_d;
  logic [CHANNELS-1:0]   mask_q, mask_d;
  logic                  ack_q, ack_d;
  logic [31:0]           rdt_q, rdt_d;

`ifdef SERVANT_TIMER_NCH_ONESHOT_EN
  logic                  oneshot_q, oneshot_d;
`else
  logic                  oneshot_q;
  assign oneshot_q = 1'b0;
`endif

  logic                  access;
  logic                  wr;
  logic                  wr_ctrl, wr_count, wr_top, wr_pending, wr_mask;
  logic [CHANNELS-1:0]   wr_cmp;
  logic                  tick;
  logic                  at_top;
  word_t                 tick_count;
  logic [CHANNELS-1:0]   match;
  logic [31:0]           rd_data;

  // A bus access is accepted on the edge that raises ack.
  // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    access     = wb.i_wb_cyc & ~ack_q;
    wr         = access & wb.i_wb_we;
    wr_ctrl    = wr && (wb.i_wb_adr == REG_CTRL);
    wr_count   = wr && (wb.i_wb_adr == REG_COUNT);
    wr_top     = wr && (wb.i_wb_adr == REG_TOP);
    wr_pending = wr && (wb.i_wb_adr == REG_PENDING);
    wr_mask    = wr && (wb.i_wb_adr == REG_MASK);
    wr_cmp     = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      wr_cmp[k] = wr && (wb.i_wb_adr == 4'(8 + k));
    end
  end

  // Match compares against the value COUNT takes on this tick; a COUNT write suppresses it.
  always_comb begin
    tick       = en_q && (pcnt_q == '0);
    at_top     = (count_q == top_q);
    tick_count = at_top ? '0 : count_q + word_t'(1);
    match      = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      match[k] = tick && !wr_count && (cmp_q[k] <= top_q) && (tick_count == cmp_q[k]);
    end
  end

  always_comb begin
    en_d      = en_q;
    presc_d   = presc_q;
    pcnt_d    = pcnt_q;
    count_d   = count_q;
    top_d     = top_q;
    cmp_d     = cmp_q;
    mask_d    = mask_q;
    pending_d = pending_q;
`ifdef SERVANT_TIMER_NCH_ONESHOT_EN
    oneshot_d = oneshot_q;
`endif

    if (en_q) begin
      pcnt_d = tick ? presc_q : pcnt_q - PRESCALE_W'(1);
    end

    if (tick) begin
      count_d = tick_count;
      if (at_top && oneshot_q) begin
        en_d = 1'b0;
      end
    end

    // Clear first, then OR in matches so a same-cycle match survives the W1C.
    if (wr_pending) begin
      pending_d = pending_q & ~wb.i_wb_dat[CHANNELS-1:0];
    end
    pending_d = pending_d | match;

    if (wr_ctrl) begin
      en_d    = wb.i_wb_dat[0];
      presc_d = wb.i_wb_dat[PRESCALE_W+7:8];
      pcnt_d  = wb.i_wb_dat[PRESCALE_W+7:8];
`ifdef SERVANT_TIMER_NCH_ONESHOT_EN
      oneshot_d = wb.i_wb_dat[1];
`endif
    end

    if (wr_count) begin
      count_d = wb.i_wb_dat[WIDTH-1:0];
      pcnt_d  = presc_q;
    end

    if (wr_top) begin
      top_d = wb.i_wb_dat[WIDTH-1:0];
    end

    if (wr_mask) begin
      mask_d = wb.i_wb_dat[CHANNELS-1:0];
    end

    for (int k = 0; k < CHANNELS; k++) begin
      if (wr_cmp[k]) begin
        cmp_d[k] = wb.i_wb_dat[WIDTH-1:0];
      end
    end
  end

  // Unimplemented indices and CMP slots beyond CHANNELS read as zero.
  always_comb begin
    rd_data = '0;
    case (wb.i_wb_adr)
      REG_CTRL: begin
        rd_data[0]              = en_q;
        rd_data[1]              = oneshot_q;
        rd_data[PRESCALE_W+7:8] = presc_q;
      end
      REG_COUNT:   rd_data[WIDTH-1:0]    = count_q;
      REG_TOP:     rd_data[WIDTH-1:0]    = top_q;
      REG_PENDING: rd_data[CHANNELS-1:0] = pending_q;
      REG_MASK:    rd_data[CHANNELS-1:0] = mask_q;
      default: begin
        for (int k = 0; k < CHANNELS; k++) begin
          if (wb.i_wb_adr == 4'(8 + k)) begin
            rd_data[WIDTH-1:0] = cmp_q[k];
          end
        end
      end
    endcase

    ack_d = wb.i_wb_cyc & ~ack_q;
    rdt_d = access ? rd_data : rdt_q;
  end

  // NOTE: sequential state is only ever updated with non-blocking assignments.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      en_q      <= 1'b0;
      presc_q   <= '0;
      pcnt_q    <= '0;
      count_q   <= '0;
      top_q     <= '1;
      pending_q <= '0;
      mask_q    <= '0;
      ack_q     <= 1'b0;
      rdt_q     <= '0;
      // NOTE: the compare bank is a small register array with a defined reset value, not a RAM.
      cmp_q     <= '{default: '0};
`ifdef SERVANT_TIMER_NCH_ONESHOT_EN
      oneshot_q <= 1'b0;
`endif
    end else begin
      en_q      <= en_d;
      presc_q   <= presc_d;
      pcnt_q    <= pcnt_d;
      count_q   <= count_d;
      top_q     <= top_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      ack_q     <= ack_d;
      rdt_q     <= rdt_d;
      cmp_q     <= cmp_d;
`ifdef SERVANT_TIMER_NCH_ONESHOT_EN
      oneshot_q <= oneshot_d;
`endif
    end
  end

  assign wb.o_wb_ack = ack_q;
  assign wb.o_wb_rdt = rdt_q;
  assign o_irq_vec   = pending_q & mask_q;
  assign o_irq       = |(pending_q & mask_q);

endmodule

// File: tb/tb_servant_timer_nch.sv
// Directed bench for servant_timer_nch: register table plus cycle-exact timer sequences.
module tb_servant_timer_nch;

  logic       clk = 1'b0;
  logic       rst;
  logic       irq;
  logic [3:0] irq_vec;

  always #5 clk = ~clk;

  servant_timer_nch_if wb_if ();

  servant_timer_nch #(
    .WIDTH      (32),
    .CHANNELS   (4),
    .PRESCALE_W (8)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .wb        (wb_if),
    .o_irq     (irq),
    .o_irq_vec (irq_vec)
  );

`ifdef SERVANT_TIMER_NCH_ONESHOT_EN
  localparam bit OS = 1'b1;
`else
  localparam bit OS = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [3:0]  adr;
    logic [31:0] dat;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Access occupies two edges: the first raises ack (write lands / data sampled), the second drops it.
  task automatic bus_write(input logic [3:0] adr, input logic [31:0] dat);
    wb_if.i_wb_adr = adr;
    wb_if.i_wb_dat = dat;
    wb_if.i_wb_we  = 1'b1;
    wb_if.i_wb_cyc = 1'b1;
    step();
    check("wr_ack", {31'b0, wb_if.o_wb_ack}, 32'd1);
    wb_if.i_wb_cyc = 1'b0;
    wb_if.i_wb_we  = 1'b0;
    step();
  endtask

  task automatic bus_read(input logic [3:0] adr, output logic [31:0] dat);
    wb_if.i_wb_adr = adr;
    wb_if.i_wb_we  = 1'b0;
    wb_if.i_wb_cyc = 1'b1;
    step();
    check("rd_ack", {31'b0, wb_if.o_wb_ack}, 32'd1);
    dat = wb_if.o_wb_rdt;
    wb_if.i_wb_cyc = 1'b0;
    step();
  endtask

  task automatic add_vec(input logic we, input logic [3:0] adr, input logic [31:0] dat,
                         input logic [31:0] exp, input string name);
    vec_t v;
    v.we   = we;
    v.adr  = adr;
    v.dat  = dat;
    v.exp  = exp;
    v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] d;

    add_vec(1'b1, 4'd2,  32'h0000_1234, 32'h0, "");
    add_vec(1'b0, 4'd2,  32'h0,         32'h0000_1234, "top_rw");
    add_vec(1'b1, 4'd4,  32'h0000_00FF, 32'h0, "");
    add_vec(1'b0, 4'd4,  32'h0,         32'h0000_000F, "mask_width");
    add_vec(1'b1, 4'd8,  32'hAAAA_5555, 32'h0, "");
    add_vec(1'b0, 4'd8,  32'h0,         32'hAAAA_5555, "cmp0_rw");
    add_vec(1'b1, 4'd11, 32'h0000_0007, 32'h0, "");
    add_vec(1'b0, 4'd11, 32'h0,         32'h0000_0007, "cmp3_rw");
    add_vec(1'b0, 4'd9,  32'h0,         32'h0000_0000, "cmp1_reset");
    add_vec(1'b1, 4'd12, 32'h0000_DEAD, 32'h0, "");
    add_vec(1'b0, 4'd12, 32'h0,         32'h0000_0000, "cmp4_absent");
    add_vec(1'b1, 4'd5,  32'h0000_0001, 32'h0, "");
    add_vec(1'b0, 4'd5,  32'h0,         32'h0000_0000, "idx5_unused");
    add_vec(1'b1, 4'd0,  32'hFFFF_FF02, 32'h0, "");
    add_vec(1'b0, 4'd0,  32'h0,         32'h0000_FF00 | (OS ? 32'h2 : 32'h0), "ctrl_fields");
    add_vec(1'b1, 4'd1,  32'h0000_0055, 32'h0, "");
    add_vec(1'b0, 4'd1,  32'h0,         32'h0000_0055, "count_rw");
    add_vec(1'b1, 4'd3,  32'h0000_000F, 32'h0, "");
    add_vec(1'b0, 4'd3,  32'h0,         32'h0000_0000, "pending_w1c_idle");

    wb_if.i_wb_adr = '0;
    wb_if.i_wb_dat = '0;
    wb_if.i_wb_we  = 1'b0;
    wb_if.i_wb_cyc = 1'b0;
    rst = 1'b1;
    steps(2);
    rst = 1'b0;

    // Reset state and ack timing
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_irq_vec", {28'b0, irq_vec}, 32'd0);
    wb_if.i_wb_adr = 4'd0;
    wb_if.i_wb_cyc = 1'b1;
    check("ack_before_edge", {31'b0, wb_if.o_wb_ack}, 32'd0);
    step();
    check("ack_one_cycle", {31'b0, wb_if.o_wb_ack}, 32'd1);
    check("rst_ctrl", wb_if.o_wb_rdt, 32'h0);
    wb_if.i_wb_cyc = 1'b0;
    step();
    check("ack_drops", {31'b0, wb_if.o_wb_ack}, 32'd0);
    bus_read(4'd1, d); check("rst_count", d, 32'h0);
    bus_read(4'd2, d); check("rst_top", d, 32'hFFFF_FFFF);
    bus_read(4'd3, d); check("rst_pending", d, 32'h0);
    bus_read(4'd4, d); check("rst_mask", d, 32'h0);

    // Register table, timer disabled
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].we) bus_write(vecs[i].adr, vecs[i].dat);
      else begin
        bus_read(vecs[i].adr, d);
        check(vecs[i].name, d, vecs[i].exp);
      end
    end

    // Prescale 3: COUNT steps on every 4th edge after the CTRL write
    bus_write(4'd2, 32'hFFFF_FFFF);
    bus_write(4'd1, 32'h0);
    bus_write(4'd0, 32'h0000_0301);
    steps(39);
    bus_read(4'd1, d); check("presc_count_40", d, 32'd10);
    bus_read(4'd1, d); check("presc_count_42", d, 32'd10);
    bus_write(4'd0, 32'h0);

    // Wrap and match: TOP=9, CMP0=5, PRESC=0
    bus_write(4'd2, 32'd9);
    bus_write(4'd8, 32'd5);
    bus_write(4'd9, 32'd20);
    bus_write(4'd10, 32'd20);
    bus_write(4'd11, 32'd20);
    bus_write(4'd4, 32'h1);
    bus_write(4'd3, 32'hF);
    bus_write(4'd1, 32'h0);
    bus_write(4'd0, 32'h1);
    steps(3);
    check("match_irq_before", {31'b0, irq}, 32'd0);
    step();
    check("match_irq_at5", {31'b0, irq}, 32'd1);
    check("match_vec_at5", {28'b0, irq_vec}, 32'h1);
    bus_read(4'd1, d); check("match_count5", d, 32'd5);
    steps(3);
    bus_read(4'd1, d); check("wrap_to_zero", d, 32'd0);
    bus_write(4'd3, 32'h1);
    check("w1c_clears", {31'b0, irq}, 32'd0);
    step();
    check("rematch_irq", {31'b0, irq}, 32'd1);

    // Collision: W1C lands on the same edge as the next CMP0 match
    steps(9);
    bus_write(4'd3, 32'h1);
    check("collision_irq", {31'b0, irq}, 32'd1);
    bus_read(4'd3, d); check("collision_pending", d, 32'h1);
    bus_write(4'd0, 32'h0);

    // Masking and multi-channel
    bus_write(4'd3, 32'hF);
    bus_write(4'd8, 32'd20);
    bus_write(4'd9, 32'd2);
    bus_write(4'd10, 32'd12);
    bus_write(4'd11, 32'd7);
    bus_write(4'd4, 32'h8);
    bus_write(4'd1, 32'd7);
    bus_read(4'd3, d); check("count_write_no_match", d, 32'h0);
    bus_write(4'd1, 32'd0);
    bus_write(4'd0, 32'h1);
    step();
    check("mc_irq_at2", {31'b0, irq}, 32'd0);
    check("mc_vec_at2", {28'b0, irq_vec}, 32'h0);
    steps(4);
    check("mc_irq_at6", {31'b0, irq}, 32'd0);
    step();
    check("mc_irq_at7", {31'b0, irq}, 32'd1);
    check("mc_vec_at7", {28'b0, irq_vec}, 32'h8);
    steps(20);
    bus_read(4'd3, d); check("mc_pending", d, 32'hA);
    bus_write(4'd1, 32'd3);
    bus_read(4'd1, d); check("count_write_beats_tick", d, 32'd4);
    bus_write(4'd0, 32'h0);

    // One-shot (free-running wrap when the macro is absent)
    bus_write(4'd2, 32'd3);
    bus_write(4'd1, 32'd0);
    bus_write(4'd4, 32'h0);
    bus_write(4'd0, 32'h3);
    steps(8);
    bus_read(4'd1, d); check("oneshot_count", d, OS ? 32'd0 : 32'd1);
    bus_read(4'd0, d); check("oneshot_ctrl", d, OS ? 32'h2 : 32'h1);

    // Reset mid-operation drops an in-flight ack
    wb_if.i_wb_adr = 4'd1;
    wb_if.i_wb_we  = 1'b0;
    wb_if.i_wb_cyc = 1'b1;
    rst = 1'b1;
    step();
    check("rst_drops_ack", {31'b0, wb_if.o_wb_ack}, 32'd0);
    rst = 1'b0;
    wb_if.i_wb_cyc = 1'b0;
    step();
    bus_read(4'd0, d); check("rst2_ctrl", d, 32'h0);
    bus_read(4'd1, d); check("rst2_count", d, 32'h0);
    bus_read(4'd2, d); check("rst2_top", d, 32'hFFFF_FFFF);
    check("rst2_irq", {31'b0, irq}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
